// File: rtl/eclair_dev_pkg.sv
// eclair_dev_pkg: shared constants for eclair bus devices (window, register map, bit positions, TX FSM states).
package eclair_dev_pkg;
    localparam logic [3:0] DEV_WINDOW = 4'b0111;
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DIVLO  = 3'd2;
    localparam logic [2:0] REG_DIVHI  = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_CLR_OVF = 7;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push, w_do_pop;
    assign o_full    = r_count == (AW+1)'(DEPTH);
    assign o_empty   = r_count == '0;
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
    always_ff @(posedge clk)
        if (w_do_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/dev_console_tx.sv
// dev_console_tx: memory-mapped 8N1 console transmitter with TX FIFO and programmable baud divisor.
// Define CONSOLE_IRQ_EN to build the empty/idle interrupt and the CTRL irq_en bit.
module dev_console_tx
    import eclair_dev_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       _sel,
    input  logic       _w,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       tx,
    output logic       irq
);
    tx_state_e r_state, w_next;
    logic [15:0] r_div, r_fdiv, r_cnt;
    logic [7:0]  r_shift, w_fifo_data, w_rdata;
    logic [2:0]  r_bit;
    logic        r_tx_en, r_ovf, r_wr_act;
    logic        w_wr_act, w_wr, w_rd, w_push, w_pop, w_ctrl_wr, w_full, w_empty, w_busy, w_bit_end, w_irq_en;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic        w_unused_count;
    assign w_wr_act       = !_sel && !_w;
    assign w_wr           = w_wr_act && !r_wr_act;
    assign w_rd           = !_sel && _w;
    assign w_push         = w_wr && addr == REG_DATA;
    assign w_ctrl_wr      = w_wr && addr == REG_CTRL;
    assign w_busy         = r_state != TX_IDLE;
    assign w_bit_end      = r_cnt == r_fdiv;
    assign w_unused_count = ^w_count;
    assign tx = (r_state == TX_START) ? 1'b0 : (r_state == TX_DATA) ? r_shift[0] : 1'b1;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .i_push(w_push), .i_data(data_in), .i_pop(w_pop),
        .o_data(w_fifo_data), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
    );

    // STOP hands straight to START when more bytes wait, so frames run back-to-back.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            TX_IDLE:  if (r_tx_en && !w_empty) begin w_pop = 1'b1; w_next = TX_START; end
            TX_START: if (w_bit_end) w_next = TX_DATA;
            TX_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = TX_STOP;
            TX_STOP:  if (w_bit_end) begin
                          w_pop  = r_tx_en && !w_empty;
                          w_next = w_pop ? TX_START : TX_IDLE;
                      end
            default:  w_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_fdiv  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_shift <= w_fifo_data;
                r_fdiv  <= r_div;
                r_cnt   <= '0;
                r_bit   <= '0;
            end else if (w_busy) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 16'd1;
                if (w_bit_end && r_state == TX_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        w_rdata[ST_OVF]   = addr == REG_STATUS && r_ovf;
        w_rdata[ST_BUSY]  = addr == REG_STATUS && w_busy;
        w_rdata[ST_FULL]  = addr == REG_STATUS && w_full;
        w_rdata[ST_EMPTY] = addr == REG_STATUS && w_empty;
        w_rdata = (addr == REG_DIVLO) ? r_div[7:0] :
                  (addr == REG_DIVHI) ? r_div[15:8] :
                  (addr == REG_CTRL)  ? {6'b0, w_irq_en, r_tx_en} : w_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= DIV_RESET;
            r_tx_en  <= 1'b0;
            r_ovf    <= 1'b0;
            r_wr_act <= 1'b0;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end else begin
            r_wr_act <= w_wr_act;
            if (w_wr && addr == REG_DIVLO) r_div[7:0] <= data_in;
            if (w_wr && addr == REG_DIVHI) r_div[15:8] <= data_in;
            if (w_ctrl_wr) r_tx_en <= data_in[CTRL_TX_EN];
            r_ovf   <= (r_ovf || (w_push && w_full && !w_pop)) && !(w_ctrl_wr && data_in[CTRL_CLR_OVF]);
            data_oe <= w_rd;
            if (w_rd) data_out <= w_rdata;
        end
    end

`ifdef CONSOLE_IRQ_EN
    logic r_irq_en, r_irq, w_irq_en_nx;
    assign w_irq_en_nx = w_ctrl_wr ? data_in[CTRL_IRQ_EN] : r_irq_en;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nx;
            r_irq    <= w_irq_en_nx && w_empty && !w_busy && !w_push;
        end
    end
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_dev_console_tx.sv
// tb_dev_console_tx: directed/randomized bench; a serial receiver model decodes tx into a byte queue.
module tb_dev_console_tx;
    logic       clk = 1'b0, reset = 1'b1, _sel = 1'b1, _w = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe, tx, irq;
    int checks = 0, errors = 0, cyc = 0, per = 16;
    byte unsigned rx_q[$];
    int           st_q[$];
    bit           ok_q[$];
    int   m_p, m_s;
    logic [7:0] m_b;
    logic m_cur;
    bit   m_good;
`ifdef CONSOLE_IRQ_EN
    localparam logic IRQ_HI = 1'b1;
    localparam logic [7:0] CTRL_RB = 8'h03;
`else
    localparam logic IRQ_HI = 1'b0;
    localparam logic [7:0] CTRL_RB = 8'h01;
`endif

    dev_console_tx dut (
        .clk(clk), .reset(reset), ._sel(_sel), ._w(_w), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Receiver: each bit must hold for exactly per cycles; start=0, stop=1.
    always begin
        @(negedge clk);
        if (tx === 1'b0 && !reset) begin
            m_p = per; m_s = cyc; m_good = 1'b1; m_b = 8'h00; m_cur = 1'b0;
            for (int k = 1; k < 10 * m_p; k++) begin
                @(negedge clk);
                if (k % m_p == 0) begin
                    m_cur = tx;
                    if (k / m_p >= 1 && k / m_p <= 8) m_b[k / m_p - 1] = tx;
                end else if (tx !== m_cur) m_good = 1'b0;
                if (k / m_p == 9 && tx !== 1'b1) m_good = 1'b0;
                if (k < m_p && tx !== 1'b0) m_good = 1'b0;
            end
            rx_q.push_back(m_b); st_q.push_back(m_s); ok_q.push_back(m_good);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; data_in = d; _sel = 1'b0; _w = 1'b0;
        @(negedge clk);
        _sel = 1'b1; _w = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        addr = a; _sel = 1'b0; _w = 1'b1;
        @(negedge clk);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_oe"}, data_oe, 1);
        _sel = 1'b1;
        @(negedge clk);
        check({tag, "_oe_off"}, data_oe, 0);
    endtask

    task automatic wait_rx(input int n, input int limit);
        int t = 0;
        while (rx_q.size() < n && t < limit) begin @(negedge clk); t++; end
        check("rx_frame_count", rx_q.size(), n);
    endtask

    task automatic clear_rx();
        rx_q.delete(); st_q.delete(); ok_q.delete();
    endtask

    function automatic logic [7:0] status(input int n, input bit ovf, input bit busy);
        return {4'b0, ovf, busy, n == 16, n == 0};
    endfunction

    initial begin
        logic [7:0] v;
        byte unsigned mq[$];
        bit movf;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_oe", data_oe, 0);
        check("rst_dout", data_out, 0);
        check("rst_irq", irq, 0);
        reset = 1'b0;
        rd_chk("rst_status", 3'd1, 8'h01);
        rd_chk("rst_divlo", 3'd2, 8'h0F);
        rd_chk("rst_divhi", 3'd3, 8'h00);
        rd_chk("rst_ctrl", 3'd4, 8'h00);
        rd_chk("rst_unmapped", 3'd6, 8'h00);

        // one-cycle bit time
        wr(3'd2, 8'h00); per = 1;
        wr(3'd4, 8'h01);
        clear_rx();
        wr(3'd0, 8'h55);
        rd_chk("t1_busy", 3'd1, status(0, 0, 1));
        wait_rx(1, 100);
        check("t1_byte", rx_q[0], 8'h55);
        check("t1_frame", ok_q[0], 1);
        rd_chk("t1_idle", 3'd1, status(0, 0, 0));

        // 4-cycle bit time, back-to-back frames
        wr(3'd2, 8'h03); per = 4;
        clear_rx();
        wr(3'd0, 8'hA3);
        wr(3'd0, 8'h01);
        wait_rx(2, 200);
        check("t2_byte0", rx_q[0], 8'hA3);
        check("t2_byte1", rx_q[1], 8'h01);
        check("t2_frames_ok", ok_q[0] && ok_q[1], 1);
        check("t2_gap", st_q[1] - st_q[0], 40);

        // overflow with tx disabled, then drain in order
        wr(3'd4, 8'h00); wr(3'd2, 8'h01); per = 2;
        clear_rx(); mq.delete(); movf = 0;
        for (int i = 0; i < 17; i++) begin
            v = 8'($urandom);
            wr(3'd0, v);
            if (mq.size() < 16) mq.push_back(v); else movf = 1;
        end
        rd_chk("t3_full_ovf", 3'd1, status(mq.size(), movf, 0));
        wr(3'd4, 8'h80);
        rd_chk("t3_ovf_clr", 3'd1, status(mq.size(), 0, 0));
        wr(3'd4, 8'h01);
        wait_rx(16, 600);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_byte%0d", i), rx_q[i], mq[i]);
            check($sformatf("t3_frame%0d", i), ok_q[i], 1);
        end
        rd_chk("t3_drained", 3'd1, status(0, 0, 0));

        // held strobe pushes once: one held write + 15 writes must fill exactly
        wr(3'd4, 8'h00);
        clear_rx(); mq.delete();
        v = 8'($urandom); mq.push_back(v);
        addr = 3'd0; data_in = v; _sel = 1'b0; _w = 1'b0;
        repeat (10) @(negedge clk);
        _sel = 1'b1; _w = 1'b1;
        @(negedge clk);
        rd_chk("t4_one", 3'd1, status(1, 0, 0));
        for (int i = 0; i < 15; i++) begin
            v = 8'($urandom); mq.push_back(v); wr(3'd0, v);
        end
        rd_chk("t4_full", 3'd1, status(16, 0, 0));
        wr(3'd4, 8'h01);
        wait_rx(16, 600);
        for (int i = 0; i < 16; i++) check($sformatf("t4_byte%0d", i), rx_q[i], mq[i]);
        repeat (40) @(negedge clk);
        check("t4_no_extra", rx_q.size(), 16);

        // interrupt
        clear_rx();
        wr(3'd4, 8'h03);
        rd_chk("t6_ctrl", 3'd4, CTRL_RB);
        repeat (3) @(negedge clk);
        check("t6_irq_idle", irq, IRQ_HI);
        wr(3'd0, 8'h41);
        check("t6_irq_push", irq, 0);
        wait_rx(1, 100);
        check("t6_byte", rx_q[0], 8'h41);
        repeat (3) @(negedge clk);
        check("t6_irq_done", irq, IRQ_HI);
        wr(3'd4, 8'h01);
        @(negedge clk);
        check("t6_irq_off", irq, 0);

        // readback and reset mid-frame
        wr(3'd3, 8'h12);
        check("t5_oe_idle", data_oe, 0);
        rd_chk("t5_divhi", 3'd3, 8'h12);
        wr(3'd3, 8'h00); wr(3'd2, 8'h03); per = 4;
        wr(3'd0, 8'h00);
        repeat (6) @(negedge clk);
        check("t5_tx_mid", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx_reset", tx, 1);
        reset = 1'b0;
        rd_chk("t5_status", 3'd1, status(0, 0, 0));
        rd_chk("t5_divlo", 3'd2, 8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
